// File: rtl/capture_sink_pkg.sv
// capture_sink_pkg
//   Shared definitions for the capture sink: receive state encoding and the
//   default sample / address widths.
//   Optional feature macro used by the block: CAPTURE_SINK_TLAST_CHECK_EN.
package capture_sink_pkg;

    localparam int SIZE_DEF    = 32;  // sample width in bits
    localparam int SADDR_W_DEF = 24;  // sample address / count width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/capture_sink_if.sv
// capture_sink_if
//   AXI-stream style sample channel between the sample FIFO (master) and the
//   capture sink (slave).
//   Signals: tdata[size] sample, tvalid, tready (slave -> master), tlast.
interface capture_sink_if #(
    parameter int size = capture_sink_pkg::SIZE_DEF
);
    logic [size-1:0] tdata;
    logic            tvalid;
    logic            tready;
    logic            tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/capture_sink.sv
// capture_sink
//   Consumer end of the capture path. Accepts samples from the stream and
//   writes them to a linear sample memory at addresses 0..buffer_size-1,
//   passing memory back-pressure straight through to the stream.
//   Ports:
//     clk, reset        single clock, synchronous active-low reset
//     s (slave)         sample stream tdata/tvalid/tready/tlast
//     start, abort      one-cycle control pulses (abort has priority)
//     buffer_size       samples expected, captured on start
//     mem_addr/wdata/we write port, combinational pass-through of the stream
//     mem_ready         memory can take a write this cycle
//     busy, done        run in progress / run completed (held until start)
//     count             samples written in the current / last run
//     tlast_err         tlast did not line up with buffer_size
//   Optional: define CAPTURE_SINK_TLAST_CHECK_EN to enable tlast checking and
//   early termination on a premature tlast; otherwise tlast is ignored.
module capture_sink
    import capture_sink_pkg::*;
#(
    parameter int size    = SIZE_DEF,
    parameter int saddr_w = SADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    capture_sink_if.slave      s,
    input  logic               start,
    input  logic               abort,
    input  logic [saddr_w-1:0] buffer_size,
    output logic [saddr_w-1:0] mem_addr,
    output logic [size-1:0]    mem_wdata,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic               busy,
    output logic               done,
    output logic [saddr_w-1:0] count,
    output logic               tlast_err
);

    localparam logic [saddr_w-1:0] CNT_ONE = saddr_w'(1);

    state_e             state_q, state_d;
    logic [saddr_w-1:0] len_q, len_d;
    logic [saddr_w-1:0] count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic in_recv;
    logic accept;
    logic final_beat;
    logic tlast_bad;
    logic early_end;

    assign in_recv = (state_q == ST_RECV);

    // A zero-length run spends one cycle in RECV; gating on a non-zero length
    // keeps that cycle from accepting a beat.
    assign s.tready   = in_recv & (|len_q) & mem_ready;
    assign accept     = s.tvalid & s.tready;
    assign final_beat = (count_q == len_q - CNT_ONE);

`ifdef CAPTURE_SINK_TLAST_CHECK_EN
    assign tlast_bad = accept & (s.tlast != final_beat);
    assign early_end = accept & s.tlast & ~final_beat;
`else
    logic unused_tlast;
    assign unused_tlast = s.tlast;
    assign tlast_bad    = 1'b0;
    assign early_end    = 1'b0;
`endif

    // Write port mirrors the stream while receiving; idle value is zero.
    assign mem_we    = accept;
    assign mem_wdata = in_recv ? s.tdata : '0;
    assign mem_addr  = in_recv ? count_q : '0;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        done_d  = done_q;
        err_d   = err_q;

        if (abort) begin
            // A beat accepted in the abort cycle is still written, so it
            // still counts; start in the same cycle is dropped.
            state_d = ST_IDLE;
            done_d  = 1'b0;
            if (accept) count_d = count_q + CNT_ONE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_RECV;
                        len_d   = buffer_size;
                        count_d = '0;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                ST_RECV: begin
                    if (len_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (accept) begin
                        count_d = count_q + CNT_ONE;
                        if (tlast_bad) err_d = 1'b1;
                        if (final_beat || early_end) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_RECV);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
    assign tlast_err = err_q;

endmodule
